// File: rtl/serial_alu_ctrl_pkg.sv
// Shared constants for the bit-serial ALU controller:
// ALUctl codes, FSM encoding and counter sizing.
package serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic ctl_legal(input logic [3:0] c);
    return (c == CTL_AND) || (c == CTL_OR)  ||
           (c == CTL_ADD) || (c == CTL_SUB) ||
           (c == CTL_SLT) || (c == CTL_NOR);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_bitslice_alu.sv
// Combinational 1-bit ALU slice: AND / OR / full add
// with optional inversion of either operand.
module bitslice_alu (
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       carry_in,
  input  logic [1:0] operation,
  output logic       result,
  output logic       carry_out
);

  logic aa;
  logic bb;
  logic sum;

  assign aa        = a ^ ainvert;
  assign bb        = b ^ binvert;
  assign sum       = aa ^ bb ^ carry_in;
  assign carry_out = (aa & bb) | (aa & carry_in) |
                     (bb & carry_in);

  always_comb begin
    result = 1'b0;
    unique case (operation)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      default: result = sum;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one slice, LSB first,
// WIDTH RUN cycles then a one-cycle DONE pulse.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] acc;
  logic [3:0]       ctl;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             finish;
  logic [1:0]       op;
  logic             s_res;
  logic             s_cout;
  logic             legal;
  logic             arith;
  logic             addsub;
  logic             ovf;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] res_fin;

  assign accept = (state == S_IDLE) && start;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign finish = (state == S_RUN) && last;
  assign op     = (ctl[1:0] == 2'b11) ? 2'b10 : ctl[1:0];
  assign legal  = ctl_legal(ctl);
  assign addsub = (ctl == CTL_ADD) || (ctl == CTL_SUB);
  assign arith  = addsub || (ctl == CTL_SLT);

  bitslice_alu u_slice (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .ainvert   (ctl[3]),
    .binvert   (ctl[2]),
    .carry_in  (carry),
    .operation (op),
    .result    (s_res),
    .carry_out (s_cout)
  );

  // In the last RUN cycle the carry flop holds carry-in of the MSB.
  assign ovf     = arith & (carry ^ s_cout);
  assign shifted = {s_res, acc};

  always_comb begin
    res_fin = '0;
    if (!legal) begin
      res_fin = '0;
    end else if (ctl == CTL_SLT) begin
      res_fin[0] = s_res ^ ovf;
    end else begin
      res_fin = shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      ctl   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      acc   <= '0;
      ctl   <= ALUctl;
      carry <= ALUctl[2] & ALUctl[1];
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= shifted[WIDTH-1:1];
      carry <= arith ? s_cout : 1'b0;
      cnt   <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else if (finish) begin
      Result   <= res_fin;
      CarryOut <= legal & addsub & s_cout;
      Zero     <= legal & (res_fin == '0);
      Overflow <= legal & ovf;
      Illegal  <= ~legal;
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl at WIDTH=8.
// Expected values are hand-computed per vector.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   ALUctl;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         CarryOut;
  logic         Zero;
  logic         Overflow;
  logic         Illegal;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ALUctl   (ALUctl),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Zero     (Zero),
    .Overflow (Overflow),
    .Illegal  (Illegal)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int lat;
  int dones;
  int first_at;
  int second_at;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [7:0] r,
                         input logic co, z, o, il);
    chk({tag, ".res"}, 32'(Result),   32'(r));
    chk({tag, ".co"},  32'(CarryOut), 32'(co));
    chk({tag, ".z"},   32'(Zero),     32'(z));
    chk({tag, ".ov"},  32'(Overflow), 32'(o));
    chk({tag, ".il"},  32'(Illegal),  32'(il));
  endtask

  // Accept edge counts as cycle 1; done expected in cycle W+1.
  task automatic run_op(input logic [3:0] c,
                        input logic [7:0] a, b);
    @(posedge clk); #1;
    ALUctl = c; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; ALUctl = 4'b0001;
    chk("busy_run", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, W + 1);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0] c;
    logic [7:0] a, b, r;
    logic       co, z, o, il;
  } vec_t;

  vec_t v [10];

  initial begin
    v = '{
      '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0},
      '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{4'b0111, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'b0111, 8'h01, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{4'b1100, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{4'b0001, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'b0000, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0},
      '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0},
      '{4'b1111, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}
    };

    reset = 1'b1; start = 1'b0;
    ALUctl = 4'b0; A = '0; B = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;

    foreach (v[i]) begin
      run_op(v[i].c, v[i].a, v[i].b);
      chk_out($sformatf("vec%0d", i),
              v[i].r, v[i].co, v[i].z, v[i].o, v[i].il);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("hold%0d", i), 32'(Result), 32'(v[i].r));
    end

    // start mid-RUN must be ignored
    @(posedge clk); #1;
    ALUctl = 4'b0010; A = 8'h7F; B = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int n = 1; n < 16; n++) begin
      if (n == 3) begin
        ALUctl = 4'b0110; A = 8'h05; B = 8'h05; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ign_dones", dones, 1);
    chk_out("ign", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

    // held start: back-to-back with one idle cycle
    @(posedge clk); #1;
    ALUctl = 4'b0010; A = 8'h01; B = 8'h02; start = 1'b1;
    first_at = 0; second_at = 0;
    for (int n = 1; n < 30; n++) begin
      @(posedge clk); #1;
      if (done && first_at == 0) first_at = n;
      else if (done && second_at == 0) second_at = n;
    end
    start = 1'b0;
    chk("b2b_gap", second_at - first_at, W + 2);
    chk("b2b_res", 32'(Result), 32'h03);
    repeat (12) @(posedge clk);

    // reset in the middle of RUN
    @(posedge clk); #1;
    ALUctl = 4'b0010; A = 8'h7F; B = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk_out("mrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("mrst_nodone", dones, 0);
    run_op(4'b0010, 8'h10, 8'h20);
    chk_out("post", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
